icache_param: RTL and testbench

//  Parametrised direct-mapped instruction cache with multi-word blocks, between the datapath fetch port and the memory controller.
//  A miss refills the whole block by issuing one single-word read per word to the controller.
//  The block also provides a whole-cache flush for self-modifying code and halt.

---
 rtl/icache_param_pkg.sv | 13 +
 rtl/icache_param_data_ram.sv | 31 +++
 rtl/icache_param.sv | 168 ++++++++++++++++
 tb/tb_icache_param.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/icache_param_pkg.sv
// Shared types and constants for the parametrised instruction cache.
//   icstate_t  : controller state (IDLE, FILL)
//   ICACHE_BAD : word driven on imemload whenever the fetch does not hit
package cache_pkg;

  typedef enum logic {
    IDLE,
    FILL
  } icstate_t;

  localparam logic [31:0] ICACHE_BAD = 32'hBAD1BAD1;

endpackage

// File: rtl/icache_param_data_ram.sv
// Data store for icache_param: NSETS sets x WPB words x 32 bits.
//   CLK            : clock for the write port
//   wen/widx/wword : write enable and location (set, word within block)
//   wdata          : write data
//   ridx/rword     : read location (asynchronous read)
//   rdata          : read data
module icache_param_data_ram #(
  parameter int unsigned NSETS = 16,
  parameter int unsigned WPB   = 2,
  localparam int unsigned IW   = $clog2(NSETS),
  localparam int unsigned CW   = (WPB > 1) ? $clog2(WPB) : 1
) (
  input  logic          CLK,
  input  logic          wen,
  input  logic [IW-1:0] widx,
  input  logic [CW-1:0] wword,
  input  logic [31:0]   wdata,
  input  logic [IW-1:0] ridx,
  input  logic [CW-1:0] rword,
  output logic [31:0]   rdata
);

  logic [31:0] mem [NSETS][WPB];

  always_ff @(posedge CLK) begin
    if (wen) mem[widx][wword] <= wdata;
  end

  assign rdata = mem[ridx][rword];

endmodule

// File: rtl/icache_param.sv
// Direct-mapped instruction cache with multi-word blocks between the fetch
// port and the memory controller. A miss refills the whole block with one
// single-word controller read per word; flush invalidates every set.
//   CLK, nRST        : clock, synchronous active-low reset
//   imemREN/imemaddr : fetch request and byte address
//   flush            : invalidate all sets (aborts a fill in progress)
//   ihit/imemload    : fetch result (imemload = BADWORD when not hitting)
//   iREN/iaddr       : controller read request and word address
//   iwait/iload      : controller busy and read data
//   hit_count/miss_count : performance counters, present only when the
//                          ICACHE_PERF_EN macro is defined
module icache_param
  import cache_pkg::*;
#(
  parameter int unsigned NSETS   = 16,
  parameter int unsigned WPB     = 2,
  parameter logic [31:0] BADWORD = ICACHE_BAD
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        imemREN,
  input  logic [31:0] imemaddr,
  input  logic        flush,
  output logic        ihit,
  output logic [31:0] imemload,
  output logic        iREN,
  output logic [31:0] iaddr,
  input  logic        iwait,
  input  logic [31:0] iload
`ifdef ICACHE_PERF_EN
  ,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
`endif
);

  localparam int unsigned BO = $clog2(WPB);
  localparam int unsigned IW = $clog2(NSETS);
  localparam int unsigned TW = 30 - BO - IW;
  localparam int unsigned CW = (BO > 0) ? BO : 1;
  localparam logic [CW-1:0] LAST_WORD = CW'(WPB - 1);

  icstate_t state, state_n;

  logic [TW-1:0] req_tag;
  logic [IW-1:0] req_idx;
  logic [CW-1:0] req_word;

  logic [TW-1:0] miss_tag;
  logic [IW-1:0] miss_idx;
  logic [CW-1:0] cnt;
  logic [NSETS-1:0] valid;
  logic [TW-1:0] tags [NSETS];

  logic [31:0] rdata;
  logic [31:0] fill_addr;
  logic        tag_hit, hit, miss, word_done, fill_done, last;
  logic        unused_byte;

  assign unused_byte = ^imemaddr[1:0];

  assign req_tag = imemaddr[31:32-TW];
  assign req_idx = imemaddr[BO+IW+1:BO+2];

  // With single-word blocks there is no word field: word index and the
  // counter collapse to a constant-zero bit.
  generate
    if (BO > 0) begin : g_multi
      assign req_word  = imemaddr[BO+1:2];
      assign fill_addr = {miss_tag, miss_idx, cnt, 2'b00};
    end else begin : g_single
      assign req_word  = '0;
      assign fill_addr = {miss_tag, miss_idx, 2'b00};
    end
  endgenerate

  assign tag_hit   = valid[req_idx] && (tags[req_idx] == req_tag);
  assign hit       = (state == IDLE) && imemREN && tag_hit && !flush;
  assign miss      = (state == IDLE) && imemREN && !tag_hit && !flush;
  assign last      = (cnt == LAST_WORD);
  assign word_done = (state == FILL) && !iwait && !flush;
  assign fill_done = word_done && last;

  icache_param_data_ram #(
    .NSETS (NSETS),
    .WPB   (WPB)
  ) u_data (
    .CLK   (CLK),
    .wen   (word_done),
    .widx  (miss_idx),
    .wword (cnt),
    .wdata (iload),
    .ridx  (req_idx),
    .rword (req_word),
    .rdata (rdata)
  );

  // State register plus valid bits and word counter.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state <= IDLE;
      cnt   <= '0;
      valid <= '0;
    end else begin
      state <= state_n;
      if (flush) begin
        valid <= '0;
      end else begin
        if (miss)      valid[req_idx]  <= 1'b0;
        if (fill_done) valid[miss_idx] <= 1'b1;
      end
      if (miss)           cnt <= '0;
      else if (word_done) cnt <= last ? '0 : cnt + 1'b1;
    end
  end

  // Tag store and latched miss address carry no reset: they are only
  // consulted behind a valid bit or while in FILL.
  always_ff @(posedge CLK) begin
    if (miss) begin
      miss_tag <= req_tag;
      miss_idx <= req_idx;
    end
    if (fill_done) tags[miss_idx] <= miss_tag;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE: if (miss) state_n = FILL;
      FILL: if (flush || fill_done) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    ihit     = 1'b0;
    imemload = BADWORD;
    iREN     = 1'b0;
    iaddr    = '0;
    case (state)
      IDLE: begin
        if (hit) begin
          ihit     = 1'b1;
          imemload = rdata;
        end
      end
      FILL: begin
        iREN  = 1'b1;
        iaddr = fill_addr;
      end
      default: ;
    endcase
  end

`ifdef ICACHE_PERF_EN
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      if (hit)  hit_count  <= hit_count + 32'd1;
      if (miss) miss_count <= miss_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_icache_param.sv
module tb_icache_param;

  logic        CLK = 1'b0;
  logic        nRST, imemREN, flush, iwait;
  logic [31:0] imemaddr, imemload, iaddr, iload;
  logic        ihit, iREN;
`ifdef ICACHE_PERF_EN
  logic [31:0] hit_count, miss_count;
`endif

  int errors = 0;
  int checks = 0;

  localparam logic [31:0] BAD = 32'hBAD1BAD1;

  always #5 CLK = ~CLK;

  // Memory model: word = address ^ A5A50000; garbage while busy.
  assign iload = iwait ? 32'hDEADBEEF : (iaddr ^ 32'hA5A50000);

  icache_param #(
    .NSETS   (16),
    .WPB     (2),
    .BADWORD (32'hBAD1BAD1)
  ) dut (
    .CLK        (CLK),
    .nRST       (nRST),
    .imemREN    (imemREN),
    .imemaddr   (imemaddr),
    .flush      (flush),
    .ihit       (ihit),
    .imemload   (imemload),
    .iREN       (iREN),
    .iaddr      (iaddr),
    .iwait      (iwait),
    .iload      (iload)
`ifdef ICACHE_PERF_EN
    ,
    .hit_count  (hit_count),
    .miss_count (miss_count)
`endif
  );

  task automatic next_cycle;
    @(posedge CLK);
    #1;
  endtask

  task automatic sample;
    @(negedge CLK);
  endtask

  task automatic test_reset;
    nRST = 1'b0; imemREN = 1'b0; flush = 1'b0; iwait = 1'b0; imemaddr = '0;
    next_cycle; next_cycle;
    sample;
    checks++; if (ihit !== 1'b0) begin errors++; $display("FAIL reset_ihit: got %b expected 0", ihit); end
    checks++; if (iREN !== 1'b0) begin errors++; $display("FAIL reset_iREN: got %b expected 0", iREN); end
    checks++; if (imemload !== BAD) begin errors++; $display("FAIL reset_imemload: got %h expected %h", imemload, BAD); end
`ifdef ICACHE_PERF_EN
    checks++; if (hit_count !== 32'd0) begin errors++; $display("FAIL reset_hit_count: got %0d expected 0", hit_count); end
    checks++; if (miss_count !== 32'd0) begin errors++; $display("FAIL reset_miss_count: got %0d expected 0", miss_count); end
`endif
  endtask

  task automatic test_refill;
    next_cycle;
    nRST = 1'b1; imemREN = 1'b1; imemaddr = 32'h40;
    sample;
    checks++; if (ihit !== 1'b0) begin errors++; $display("FAIL refill_miss_ihit: got %b expected 0", ihit); end
    checks++; if (iREN !== 1'b0) begin errors++; $display("FAIL refill_miss_iREN: got %b expected 0", iREN); end
    next_cycle; sample;
    checks++; if (iREN !== 1'b1 || iaddr !== 32'h40) begin errors++; $display("FAIL refill_w0: got iREN=%b iaddr=%h expected 1/00000040", iREN, iaddr); end
    checks++; if (ihit !== 1'b0) begin errors++; $display("FAIL refill_fill_ihit: got %b expected 0", ihit); end
    next_cycle; sample;
    checks++; if (iREN !== 1'b1 || iaddr !== 32'h44) begin errors++; $display("FAIL refill_w1: got iREN=%b iaddr=%h expected 1/00000044", iREN, iaddr); end
    next_cycle; sample;
    checks++; if (ihit !== 1'b1 || imemload !== 32'hA5A50040) begin errors++; $display("FAIL refill_hit: got ihit=%b data=%h expected 1/a5a50040", ihit, imemload); end
    checks++; if (iREN !== 1'b0) begin errors++; $display("FAIL refill_hit_iREN: got %b expected 0", iREN); end
  endtask

  task automatic test_hit_same_cycle;
    next_cycle;
    imemaddr = 32'h44;
    sample;
    checks++; if (ihit !== 1'b1 || imemload !== 32'hA5A50044) begin errors++; $display("FAIL hit44: got ihit=%b data=%h expected 1/a5a50044", ihit, imemload); end
    checks++; if (iREN !== 1'b0) begin errors++; $display("FAIL hit44_iREN: got %b expected 0", iREN); end
  endtask

  task automatic test_evict;
    next_cycle;
    imemaddr = 32'h440;
    sample;
    checks++; if (ihit !== 1'b0) begin errors++; $display("FAIL evict440_miss: got %b expected 0", ihit); end
    next_cycle; sample;
    checks++; if (iaddr !== 32'h440) begin errors++; $display("FAIL evict440_w0: got %h expected 00000440", iaddr); end
    next_cycle; sample;
    checks++; if (iaddr !== 32'h444) begin errors++; $display("FAIL evict440_w1: got %h expected 00000444", iaddr); end
    next_cycle; sample;
    checks++; if (ihit !== 1'b1 || imemload !== 32'hA5A50440) begin errors++; $display("FAIL evict440_hit: got ihit=%b data=%h expected 1/a5a50440", ihit, imemload); end
    next_cycle;
    imemaddr = 32'h40;
    sample;
    checks++; if (ihit !== 1'b0) begin errors++; $display("FAIL evict40_miss: got %b expected 0", ihit); end
    next_cycle; next_cycle; next_cycle; sample;
    checks++; if (ihit !== 1'b1 || imemload !== 32'hA5A50040) begin errors++; $display("FAIL evict40_hit: got ihit=%b data=%h expected 1/a5a50040", ihit, imemload); end
`ifdef ICACHE_PERF_EN
    // Three misses (0x40, 0x440, 0x40) and three earlier hit cycles counted.
    checks++; if (miss_count !== 32'd3) begin errors++; $display("FAIL evict_miss_count: got %0d expected 3", miss_count); end
    checks++; if (hit_count !== 32'd3) begin errors++; $display("FAIL evict_hit_count: got %0d expected 3", hit_count); end
`endif
  endtask

  task automatic test_iwait;
    next_cycle;
    imemaddr = 32'h80; iwait = 1'b1;
    sample;
    checks++; if (ihit !== 1'b0) begin errors++; $display("FAIL iwait_miss: got %b expected 0", ihit); end
    for (int i = 0; i < 5; i++) begin
      next_cycle; sample;
      checks++; if (iREN !== 1'b1 || iaddr !== 32'h80) begin errors++; $display("FAIL iwait_hold%0d: got iREN=%b iaddr=%h expected 1/00000080", i, iREN, iaddr); end
    end
    next_cycle;
    iwait = 1'b0;
    sample;
    checks++; if (iaddr !== 32'h80) begin errors++; $display("FAIL iwait_w0: got %h expected 00000080", iaddr); end
    next_cycle; sample;
    checks++; if (iaddr !== 32'h84) begin errors++; $display("FAIL iwait_w1: got %h expected 00000084", iaddr); end
    next_cycle; sample;
    checks++; if (ihit !== 1'b1 || imemload !== 32'hA5A50080) begin errors++; $display("FAIL iwait_hit: got ihit=%b data=%h expected 1/a5a50080", ihit, imemload); end
  endtask

  task automatic test_flush;
    next_cycle;
    imemaddr = 32'hC0;
    sample;
    next_cycle; sample;
    checks++; if (iaddr !== 32'hC0) begin errors++; $display("FAIL flush_w0: got %h expected 000000c0", iaddr); end
    next_cycle;
    flush = 1'b1;
    sample;
    checks++; if (iaddr !== 32'hC4) begin errors++; $display("FAIL flush_w1: got %h expected 000000c4", iaddr); end
    next_cycle;
    flush = 1'b0;
    sample;
    checks++; if (iREN !== 1'b0 || ihit !== 1'b0) begin errors++; $display("FAIL flush_abort: got iREN=%b ihit=%b expected 0/0", iREN, ihit); end
    next_cycle; sample;
    checks++; if (iREN !== 1'b1 || iaddr !== 32'hC0) begin errors++; $display("FAIL flush_restart: got iREN=%b iaddr=%h expected 1/000000c0", iREN, iaddr); end
    next_cycle; sample;
    checks++; if (iaddr !== 32'hC4) begin errors++; $display("FAIL flush_restart_w1: got %h expected 000000c4", iaddr); end
    next_cycle; sample;
    checks++; if (ihit !== 1'b1 || imemload !== 32'hA5A500C0) begin errors++; $display("FAIL flush_refill_hit: got ihit=%b data=%h expected 1/a5a500c0", ihit, imemload); end
    // Flush against a would-be hit: flush wins.
    next_cycle;
    flush = 1'b1;
    sample;
    checks++; if (ihit !== 1'b0 || imemload !== BAD) begin errors++; $display("FAIL flush_vs_hit: got ihit=%b data=%h expected 0/%h", ihit, imemload, BAD); end
    next_cycle;
    flush = 1'b0; imemaddr = 32'h80;
    sample;
    checks++; if (ihit !== 1'b0) begin errors++; $display("FAIL flush_all_sets: got %b expected 0", ihit); end
    next_cycle; next_cycle; next_cycle; sample;
    checks++; if (ihit !== 1'b1 || imemload !== 32'hA5A50080) begin errors++; $display("FAIL flush_refetch80: got ihit=%b data=%h expected 1/a5a50080", ihit, imemload); end
  endtask

  task automatic test_reset_fill;
    next_cycle;
    imemaddr = 32'h100;
    sample;
    next_cycle;
    nRST = 1'b0;
    sample;
    checks++; if (iREN !== 1'b1 || iaddr !== 32'h100) begin errors++; $display("FAIL rstfill_w0: got iREN=%b iaddr=%h expected 1/00000100", iREN, iaddr); end
    next_cycle;
    nRST = 1'b1;
    sample;
    checks++; if (iREN !== 1'b0) begin errors++; $display("FAIL rstfill_iREN: got %b expected 0", iREN); end
    checks++; if (ihit !== 1'b0 || imemload !== BAD) begin errors++; $display("FAIL rstfill_out: got ihit=%b data=%h expected 0/%h", ihit, imemload, BAD); end
`ifdef ICACHE_PERF_EN
    checks++; if (hit_count !== 32'd0) begin errors++; $display("FAIL rstfill_hit_count: got %0d expected 0", hit_count); end
    checks++; if (miss_count !== 32'd0) begin errors++; $display("FAIL rstfill_miss_count: got %0d expected 0", miss_count); end
`endif
    imemREN = 1'b0;
  endtask

  initial begin
    test_reset;
    test_refill;
    test_hit_same_cycle;
    test_evict;
    test_iwait;
    test_flush;
    test_reset_fill;
    next_cycle;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
